// File: rtl/weight_bank_if.sv
// weight_bank_if: init/row read-write bundle between the config path and weight_bank
interface weight_bank_if #(
  parameter int W = 10,
  parameter int LANES = 10,
  parameter int ROWS = 10
);
  localparam int ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  logic init;
  logic [15:0] seed;
  logic we;
  logic [LANES-1:0] wr_mask;
  logic re;
  logic [ADDR_W-1:0] address;
  logic [LANES*W-1:0] d;
  logic [LANES*W-1:0] weight;
  logic valid;
  logic addr_err;
  logic busy;
  logic ready;
  modport master (
    output init, seed, we, wr_mask, re, address, d,
    input  weight, valid, addr_err, busy, ready
  );
  modport slave (
    input  init, seed, we, wr_mask, re, address, d,
    output weight, valid, addr_err, busy, ready
  );
endinterface

// File: rtl/weight_bank.sv
// weight_bank: LFSR-initialised ROWS x LANES signed weight memory with masked row writes and registered reads
module weight_bank #(
  parameter int W = 10,
  parameter int LANES = 10,
  parameter int ROWS = 10,
  parameter int SHIFT = 0
) (
  input logic clk,
  input logic rst_n,
  weight_bank_if.slave bus
);
  localparam int ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int N = ROWS * LANES;
  localparam int K_W = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, INIT, READY} state_t;
  state_t state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [K_W-1:0] k_q, k_d;
  logic [LANES*W-1:0] weight_q, weight_d;
  logic valid_q, valid_d;
  logic addr_err_q, addr_err_d;
  logic [W-1:0] mem_q [ROWS][LANES];
  logic [W-1:0] mem_d [ROWS][LANES];
  logic start, addr_ok, rd_acc, wr_acc;
  logic signed [W-1:0] init_w;
  logic [ADDR_W-1:0] init_row;
  logic [LANE_W-1:0] init_lane;
  logic [LANES*W-1:0] row_rd;
  always_comb begin
    start = bus.init && state_q != INIT;
    addr_ok = int'(bus.address) < ROWS;
    rd_acc = state_q == READY && !bus.init && bus.re;
    wr_acc = state_q == READY && !bus.init && bus.we;
    init_w = $signed(lfsr_q[W-1:0]) >>> SHIFT;
    init_row = ADDR_W'(k_q / K_W'(LANES));
    init_lane = LANE_W'(k_q % K_W'(LANES));
    row_rd = '0;
    for (int i = 0; i < LANES; i++) row_rd[i*W +: W] = addr_ok ? mem_q[bus.address][i] : '0;
    mem_d = mem_q;
    if (state_q == INIT) mem_d[init_row][init_lane] = init_w;
    for (int i = 0; i < LANES; i++)
      if (wr_acc && addr_ok && bus.wr_mask[i]) mem_d[bus.address][i] = bus.d[i*W +: W];
    state_d = state_q;
    lfsr_d = lfsr_q;
    k_d = k_q;
    if (start) begin
      state_d = INIT;
      lfsr_d = (bus.seed == '0) ? 16'hACE1 : bus.seed;
      k_d = '0;
    end else if (state_q == INIT) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      k_d = k_q + K_W'(1);
      state_d = (k_q == K_W'(N - 1)) ? READY : INIT;
    end
    valid_d = rd_acc;
    addr_err_d = (rd_acc || wr_acc) && !addr_ok;
    weight_d = rd_acc ? row_rd : weight_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q <= 16'h0001;
      k_q <= '0;
      weight_q <= '0;
      valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      k_q <= k_d;
      weight_q <= weight_d;
      valid_q <= valid_d;
      addr_err_q <= addr_err_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign bus.weight = weight_q;
  assign bus.valid = valid_q;
  assign bus.addr_err = addr_err_q;
  assign bus.busy = state_q == INIT;
  assign bus.ready = state_q == READY;
endmodule

// File: tb/tb_weight_bank.sv
// tb_weight_bank: scoreboard bench driving a SHIFT=0 and a SHIFT=2 weight_bank in lockstep
module tb_weight_bank;
  localparam int W = 10;
  localparam int LANES = 10;
  localparam int ROWS = 10;
  localparam int AW = 4;
  localparam int N = ROWS * LANES;
  localparam int VW = LANES * W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  logic [VW-1:0] q0 [$];
  logic [VW-1:0] q2 [$];
  logic [W-1:0] m0 [N];
  logic [W-1:0] m2 [N];
  always #5 clk = ~clk;
  weight_bank_if #(.W(W), .LANES(LANES), .ROWS(ROWS)) bus ();
  weight_bank_if #(.W(W), .LANES(LANES), .ROWS(ROWS)) bus2 ();
  weight_bank #(.W(W), .LANES(LANES), .ROWS(ROWS), .SHIFT(0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  weight_bank #(.W(W), .LANES(LANES), .ROWS(ROWS), .SHIFT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  assign bus2.init = bus.init;
  assign bus2.seed = bus.seed;
  assign bus2.we = bus.we;
  assign bus2.wr_mask = bus.wr_mask;
  assign bus2.re = bus.re;
  assign bus2.address = bus.address;
  assign bus2.d = bus.d;
  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.valid) begin
      if (q0.size() == 0) chk("rd0_unexpected", 1, 0);
      else chk("rd0", bus.weight, q0.pop_front());
    end
    if (bus2.valid) begin
      if (q2.size() == 0) chk("rd2_unexpected", 1, 0);
      else chk("rd2", bus2.weight, q2.pop_front());
    end
  end
  task automatic model_init(input logic [15:0] s);
    logic [15:0] l;
    l = (s == 16'h0) ? 16'hACE1 : s;
    for (int k = 0; k < N; k++) begin
      m0[k] = l[W-1:0];
      m2[k] = W'($signed(l[W-1:0]) >>> 2);
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endtask
  function automatic logic [VW-1:0] mrow(input bit s2, input int r);
    logic [VW-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*W +: W] = s2 ? m2[r*LANES+i] : m0[r*LANES+i];
    return v;
  endfunction
  task automatic rd_exp(input int r, input logic [VW-1:0] e0, input logic [VW-1:0] e2);
    bus.address = AW'(r);
    bus.re = 1'b1;
    q0.push_back(e0);
    q2.push_back(e2);
    @(negedge clk);
    bus.re = 1'b0;
    chk("valid_lat", bus.valid & bus2.valid, 1);
  endtask
  task automatic rd(input int r);
    if (r < ROWS) rd_exp(r, mrow(0, r), mrow(1, r));
    else rd_exp(r, '0, '0);
  endtask
  task automatic rd_all();
    for (int r = 0; r < ROWS; r++) rd(r);
  endtask
  task automatic model_wr(input int r, input logic [LANES-1:0] m, input logic [VW-1:0] dv);
    if (r < ROWS)
      for (int i = 0; i < LANES; i++)
        if (m[i]) begin
          m0[r*LANES+i] = dv[i*W +: W];
          m2[r*LANES+i] = dv[i*W +: W];
        end
  endtask
  task automatic wr(input int r, input logic [LANES-1:0] m, input logic [VW-1:0] dv);
    bus.address = AW'(r);
    bus.wr_mask = m;
    bus.d = dv;
    bus.we = 1'b1;
    model_wr(r, m, dv);
    @(negedge clk);
    bus.we = 1'b0;
  endtask
  task automatic do_init(input logic [15:0] s, input bit with_re);
    int cnt;
    cnt = 0;
    bus.init = 1'b1;
    bus.seed = s;
    bus.re = with_re;
    bus.address = '0;
    model_init(s);
    @(negedge clk);
    bus.init = 1'b0;
    bus.re = 1'b0;
    chk("init_drops_re", bus.valid | bus2.valid, 0);
    while (bus.busy && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", cnt, 100);
    chk("ready", {bus.ready, bus2.ready, bus.busy, bus2.busy}, 4'b1100);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [VW-1:0] dv;
    bus.init = 1'b0;
    bus.seed = '0;
    bus.we = 1'b0;
    bus.wr_mask = '0;
    bus.re = 1'b0;
    bus.address = '0;
    bus.d = '0;
    #100;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_weight", bus.weight | bus2.weight, '0);
    chk("rst_flags", {bus.valid, bus.busy, bus.ready, bus.addr_err}, 4'b0000);
    bus.we = 1'b1;
    bus.re = 1'b1;
    bus.address = AW'(12);
    @(negedge clk);
    bus.we = 1'b0;
    bus.re = 1'b0;
    chk("idle_ignore", {bus.valid, bus.addr_err, bus2.valid, bus2.addr_err}, 4'b0000);
    do_init(16'h0001, 1'b0);
    rd_exp(0, {10'h200, 10'h100, 10'h080, 10'h040, 10'h020, 10'h010, 10'h008, 10'h004, 10'h002, 10'h001},
              {10'h380, 10'h040, 10'h020, 10'h010, 10'h008, 10'h004, 10'h002, 10'h001, 10'h000, 10'h000});
    @(negedge clk);
    chk("valid_drop", bus.valid, 0);
    rd_all();
    do_init(16'h0000, 1'b1);
    rd_all();
    do_init(16'hACE1, 1'b0);
    rd_all();
    dv = {LANES{10'h3FF}};
    dv[0 +: W] = 10'h155;
    dv[2*W +: W] = 10'h0AA;
    wr(3, 10'b0000000101, dv);
    rd(3);
    for (int i = 0; i < LANES; i++) dv[i*W +: W] = W'(i + 1);
    bus.address = AW'(3);
    bus.re = 1'b1;
    bus.we = 1'b1;
    bus.wr_mask = '1;
    bus.d = dv;
    q0.push_back(mrow(0, 3));
    q2.push_back(mrow(1, 3));
    model_wr(3, '1, dv);
    @(negedge clk);
    bus.re = 1'b0;
    bus.we = 1'b0;
    rd(3);
    rd(12);
    chk("addr_err_rd", {bus.addr_err, bus2.addr_err}, 2'b11);
    @(negedge clk);
    chk("addr_err_clr", {bus.addr_err, bus2.addr_err}, 2'b00);
    wr(12, '1, '0);
    chk("addr_err_wr", {bus.addr_err, bus.valid}, 2'b10);
    @(negedge clk);
    chk("addr_err_clr2", bus.addr_err, 0);
    rd_all();
    @(negedge clk);
    bus.init = 1'b1;
    bus.seed = 16'h5A5A;
    @(negedge clk);
    bus.init = 1'b0;
    repeat (39) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_init", {bus.busy, bus.ready, bus2.busy, bus2.ready}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    do_init(16'h1234, 1'b0);
    rd_all();
    repeat (3) @(negedge clk);
    chk("queues_drained", q0.size() + q2.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
